rs232_to_axis: RTL



---
 rtl/rs232_rx_fifo.sv | 45 ++++
 rtl/rs232_to_axis.sv | 108 ++++++++++
 2 files changed

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: synchronous byte FIFO with push/pop, a registered head and an occupancy count.
// A push that arrives while the FIFO is full and not being popped is dropped and flagged.
module rs232_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [7:0]                    i_data,
  input  logic                          i_pop,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_wr;
  assign o_valid   = r_count != '0;
  assign w_pop     = i_pop && o_valid;
  assign w_wr      = i_push && (r_count != FULL || w_pop);
  assign o_overrun = i_push && !w_wr;
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  // storage is reset so the head reads 0 until the first byte arrives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem   <= '{default: 8'h00};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/rs232_to_axis.sv
// rs232_to_axis: 16x-oversampling 8N1 receiver feeding a byte FIFO presented as an AXI byte stream,
// with rtsn flow control that holds off the remote sender before the FIFO overflows.
module rs232_to_axis #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int RTS_MARGIN = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rxd,
  output logic       rtsn,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       ferror,
  output logic       overrun
);
  localparam int SAMPLE_COUNT = CLOCK_FREQ / (16 * BAUD_RATE);
  localparam int TW = $clog2(SAMPLE_COUNT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(SAMPLE_COUNT - 1);
  localparam logic [CW-1:0] RTS_LEVEL   = CW'(FIFO_DEPTH - RTS_MARGIN);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t        r_state, w_state_nxt;
  logic          r_rx1, r_rxs;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_phase, w_ph;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_s7, r_s8;
  logic          r_rtsn, r_ferror, r_overrun;
  logic          w_tick, w_restart, w_push, w_ferr, w_ovr, w_maj;
  logic [CW-1:0] w_count, w_count_nxt;
  assign w_tick      = r_tcnt == '0;
  assign w_ph        = r_phase + 4'd1;
  assign w_maj       = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
  assign w_count_nxt = w_count + CW'(w_push && !w_ovr) - CW'(ovalid && oready);
  assign rtsn        = r_rtsn;
  assign ferror      = r_ferror;
  assign overrun     = r_overrun;
  // events fire on the tick that advances the phase to the named value
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: if (!r_rxs) begin
        w_state_nxt = START;
        w_restart   = 1'b1;
      end
      START: if (w_tick && w_ph == 4'd8 && r_rxs) w_state_nxt = IDLE;
        else if (w_tick && w_ph == 4'd15) w_state_nxt = DATA;
      DATA: if (w_tick && w_ph == 4'd15 && r_bit == 3'd7) w_state_nxt = STOP;
      STOP: if (w_tick && w_ph == 4'd8) begin
        w_state_nxt = r_rxs ? IDLE : BREAK;
        w_push      = r_rxs;
        w_ferr      = !r_rxs;
      end
      BREAK: if (r_rxs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_rx1     <= 1'b1;
      r_rxs     <= 1'b1;
      r_tcnt    <= TICK_RELOAD;
      r_phase   <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_rtsn    <= 1'b1;
      r_ferror  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rx1     <= rxd;
      r_rxs     <= r_rx1;
      r_tcnt    <= (w_restart || w_tick) ? TICK_RELOAD : r_tcnt - TW'(1);
      r_phase   <= w_restart ? 4'd0 : w_tick ? w_ph : r_phase;
      r_ferror  <= w_ferr;
      r_overrun <= w_ovr;
      r_rtsn    <= w_count_nxt >= RTS_LEVEL;
      if (r_state == START) r_bit <= '0;
      else if (r_state == DATA && w_tick && w_ph == 4'd15) r_bit <= r_bit + 3'd1;
      if (r_state == DATA && w_tick) begin
        if (w_ph == 4'd7) r_s7 <= r_rxs;
        if (w_ph == 4'd8) r_s8 <= r_rxs;
        if (w_ph == 4'd9) r_shift <= {w_maj, r_shift[7:1]};
      end
    end
  end
  rs232_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (clock),
    .i_rst_n   (resetn),
    .i_push    (w_push),
    .i_data    (r_shift),
    .i_pop     (oready),
    .o_data    (odata),
    .o_valid   (ovalid),
    .o_count   (w_count),
    .o_overrun (w_ovr)
  );
endmodule
